// File: rtl/bulk_ep_arbiter.sv
// Routes USB bulk IN/OUT transfers between the protocol layer and two endpoints (A/B).
// Optional packet statistics outputs are enabled by defining BULK_ARB_STATS_EN.
module bulk_ep_arbiter #(
  parameter logic [3:0]  EP_A_NUM = 4'd1,
  parameter logic [3:0]  EP_B_NUM = 4'd2,
  parameter int unsigned MAX_PKT  = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] blk_xfer_endpoint_i,
  input  logic       tlp_blk_in_xfer_i,
  output logic       tlp_blk_xfer_in_has_data_o,
  output logic [7:0] tlp_blk_xfer_in_data_o,
  output logic       tlp_blk_xfer_in_data_valid_o,
  output logic       tlp_blk_xfer_in_data_last_o,
  input  logic       tlp_blk_xfer_in_data_ready_i,
  input  logic       tlp_blk_out_xfer_i,
  output logic       tlp_blk_xfer_out_ready_read_o,
  input  logic [7:0] tlp_blk_xfer_out_data_i,
  input  logic       tlp_blk_xfer_out_data_valid_i,
  output logic       epa_in_xfer_o,
  input  logic       epa_in_has_data_i,
  input  logic       epa_in_tvalid_i,
  input  logic       epa_in_tlast_i,
  input  logic [7:0] epa_in_tdata_i,
  output logic       epa_in_tready_o,
  output logic       epa_out_xfer_o,
  input  logic       epa_out_ready_read_i,
  output logic       epa_out_tvalid_o,
  output logic       epa_out_tlast_o,
  output logic [7:0] epa_out_tdata_o,
  output logic       epb_in_xfer_o,
  input  logic       epb_in_has_data_i,
  input  logic       epb_in_tvalid_i,
  input  logic       epb_in_tlast_i,
  input  logic [7:0] epb_in_tdata_i,
  output logic       epb_in_tready_o,
  output logic       epb_out_xfer_o,
  input  logic       epb_out_ready_read_i,
  output logic       epb_out_tvalid_o,
  output logic       epb_out_tlast_o,
  output logic [7:0] epb_out_tdata_o
`ifdef BULK_ARB_STATS_EN
  ,
  output logic [15:0] stat_in_pkts_o,
  output logic [15:0] stat_out_pkts_o
`endif
);

  localparam int unsigned CntW = $clog2(MAX_PKT) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_PKT - 1);

  typedef enum logic [2:0] {StIdle, StInA, StInB, StOutA, StOutB, StDrop} state_e;

  state_e          state_q, state_d;
  logic            drop_in_q, drop_in_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            epa_tv_q, epa_tv_d, epa_tl_q, epa_tl_d;
  logic            epb_tv_q, epb_tv_d, epb_tl_q, epb_tl_d;
  logic            sel_a, sel_b, in_beat;

  assign sel_a = (blk_xfer_endpoint_i == EP_A_NUM);
  assign sel_b = (blk_xfer_endpoint_i == EP_B_NUM) && !sel_a;

  assign tlp_blk_xfer_in_has_data_o = sel_a ? epa_in_has_data_i :
                                      sel_b ? epb_in_has_data_i : 1'b0;
  assign tlp_blk_xfer_out_ready_read_o = sel_a ? epa_out_ready_read_i :
                                         sel_b ? epb_out_ready_read_i : 1'b0;

  // IN pass-through; blocked once a packet has been cut at MAX_PKT.
  always_comb begin
    tlp_blk_xfer_in_data_o       = 8'h00;
    tlp_blk_xfer_in_data_valid_o = 1'b0;
    tlp_blk_xfer_in_data_last_o  = 1'b0;
    epa_in_tready_o              = 1'b0;
    epb_in_tready_o              = 1'b0;
    if (state_q == StInA && !done_q) begin
      tlp_blk_xfer_in_data_o       = epa_in_tdata_i;
      tlp_blk_xfer_in_data_valid_o = epa_in_tvalid_i;
      tlp_blk_xfer_in_data_last_o  = epa_in_tlast_i || (cnt_q == LastCnt);
      epa_in_tready_o              = tlp_blk_xfer_in_data_ready_i;
    end else if (state_q == StInB && !done_q) begin
      tlp_blk_xfer_in_data_o       = epb_in_tdata_i;
      tlp_blk_xfer_in_data_valid_o = epb_in_tvalid_i;
      tlp_blk_xfer_in_data_last_o  = epb_in_tlast_i || (cnt_q == LastCnt);
      epb_in_tready_o              = tlp_blk_xfer_in_data_ready_i;
    end
  end

  assign in_beat = tlp_blk_xfer_in_data_valid_o && tlp_blk_xfer_in_data_ready_i;

  always_comb begin
    state_d    = state_q;
    drop_in_d  = drop_in_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    out_data_d = out_data_q;
    epa_tv_d   = 1'b0;
    epa_tl_d   = 1'b0;
    epb_tv_d   = 1'b0;
    epb_tl_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tlp_blk_in_xfer_i) begin
          cnt_d     = '0;
          done_d    = 1'b0;
          drop_in_d = 1'b1;
          state_d   = sel_a ? StInA : sel_b ? StInB : StDrop;
        end else if (tlp_blk_out_xfer_i) begin
          hold_vld_d = 1'b0;
          drop_in_d  = 1'b0;
          state_d    = sel_a ? StOutA : sel_b ? StOutB : StDrop;
        end
      end
      StInA, StInB: begin
        if (in_beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) done_d = 1'b1;
        end
        if (!tlp_blk_in_xfer_i) state_d = StIdle;
      end
      StOutA, StOutB: begin
        // A byte is only released once its successor (or end of transfer) is known.
        if (!tlp_blk_out_xfer_i) begin
          if (hold_vld_q) begin
            out_data_d = hold_q;
            epa_tv_d   = (state_q == StOutA);
            epa_tl_d   = (state_q == StOutA);
            epb_tv_d   = (state_q == StOutB);
            epb_tl_d   = (state_q == StOutB);
          end
          hold_vld_d = 1'b0;
          state_d    = StIdle;
        end else if (tlp_blk_xfer_out_data_valid_i) begin
          if (hold_vld_q) begin
            out_data_d = hold_q;
            epa_tv_d   = (state_q == StOutA);
            epb_tv_d   = (state_q == StOutB);
          end
          hold_d     = tlp_blk_xfer_out_data_i;
          hold_vld_d = 1'b1;
        end
      end
      StDrop: begin
        if (drop_in_q ? !tlp_blk_in_xfer_i : !tlp_blk_out_xfer_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      drop_in_q  <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      out_data_q <= 8'h00;
      epa_tv_q   <= 1'b0;
      epa_tl_q   <= 1'b0;
      epb_tv_q   <= 1'b0;
      epb_tl_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_in_q  <= drop_in_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      out_data_q <= out_data_d;
      epa_tv_q   <= epa_tv_d;
      epa_tl_q   <= epa_tl_d;
      epb_tv_q   <= epb_tv_d;
      epb_tl_q   <= epb_tl_d;
    end
  end

  assign epa_in_xfer_o    = (state_q == StInA);
  assign epb_in_xfer_o    = (state_q == StInB);
  assign epa_out_xfer_o   = (state_q == StOutA);
  assign epb_out_xfer_o   = (state_q == StOutB);
  assign epa_out_tvalid_o = epa_tv_q;
  assign epa_out_tlast_o  = epa_tl_q;
  assign epa_out_tdata_o  = out_data_q;
  assign epb_out_tvalid_o = epb_tv_q;
  assign epb_out_tlast_o  = epb_tl_q;
  assign epb_out_tdata_o  = out_data_q;

`ifdef BULK_ARB_STATS_EN
  logic [15:0] stat_in_q, stat_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_in_q  <= 16'h0000;
      stat_out_q <= 16'h0000;
    end else begin
      if ((state_q == StInA || state_q == StInB) && state_d == StIdle) begin
        stat_in_q <= stat_in_q + 16'd1;
      end
      if ((state_q == StOutA || state_q == StOutB) && state_d == StIdle) begin
        stat_out_q <= stat_out_q + 16'd1;
      end
    end
  end

  assign stat_in_pkts_o  = stat_in_q;
  assign stat_out_pkts_o = stat_out_q;
`endif

endmodule

// File: tb/tb_bulk_ep_arbiter.sv
// Directed bench for bulk_ep_arbiter with MAX_PKT=8.
module tb_bulk_ep_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ep;
  logic       in_xfer, out_xfer, in_ready, out_valid;
  logic [7:0] out_data;
  logic       has_data, ready_read, in_valid, in_last;
  logic [7:0] in_data;
  logic       epa_in_xfer, epa_has, epa_tv, epa_tl, epa_tr, epa_out_xfer, epa_rr;
  logic       epa_otv, epa_otl;
  logic [7:0] epa_td, epa_otd;
  logic       epb_in_xfer, epb_has, epb_tv, epb_tl, epb_tr, epb_out_xfer, epb_rr;
  logic       epb_otv, epb_otl;
  logic [7:0] epb_td, epb_otd;

  int checks = 0;
  int failures = 0;
  int epa_beats = 0, epa_lasts = 0;
  logic [7:0] epb_q_data[$];
  logic       epb_q_last[$];

  always #5 clk = ~clk;

  bulk_ep_arbiter #(.EP_A_NUM(4'd1), .EP_B_NUM(4'd2), .MAX_PKT(8)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .blk_xfer_endpoint_i           (ep),
    .tlp_blk_in_xfer_i             (in_xfer),
    .tlp_blk_xfer_in_has_data_o    (has_data),
    .tlp_blk_xfer_in_data_o        (in_data),
    .tlp_blk_xfer_in_data_valid_o  (in_valid),
    .tlp_blk_xfer_in_data_last_o   (in_last),
    .tlp_blk_xfer_in_data_ready_i  (in_ready),
    .tlp_blk_out_xfer_i            (out_xfer),
    .tlp_blk_xfer_out_ready_read_o (ready_read),
    .tlp_blk_xfer_out_data_i       (out_data),
    .tlp_blk_xfer_out_data_valid_i (out_valid),
    .epa_in_xfer_o                 (epa_in_xfer),
    .epa_in_has_data_i             (epa_has),
    .epa_in_tvalid_i               (epa_tv),
    .epa_in_tlast_i                (epa_tl),
    .epa_in_tdata_i                (epa_td),
    .epa_in_tready_o               (epa_tr),
    .epa_out_xfer_o                (epa_out_xfer),
    .epa_out_ready_read_i          (epa_rr),
    .epa_out_tvalid_o              (epa_otv),
    .epa_out_tlast_o               (epa_otl),
    .epa_out_tdata_o               (epa_otd),
    .epb_in_xfer_o                 (epb_in_xfer),
    .epb_in_has_data_i             (epb_has),
    .epb_in_tvalid_i               (epb_tv),
    .epb_in_tlast_i                (epb_tl),
    .epb_in_tdata_i                (epb_td),
    .epb_in_tready_o               (epb_tr),
    .epb_out_xfer_o                (epb_out_xfer),
    .epb_out_ready_read_i          (epb_rr),
    .epb_out_tvalid_o              (epb_otv),
    .epb_out_tlast_o               (epb_otl),
    .epb_out_tdata_o               (epb_otd)
  );

  always @(negedge clk) begin
    if (epa_otv) begin
      epa_beats++;
      if (epa_otl) epa_lasts++;
    end
    if (epb_otv) begin
      epb_q_data.push_back(epb_otd);
      epb_q_last.push_back(epb_otl);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats;
    rst = 1'b1; ep = 4'd0; in_xfer = 0; out_xfer = 0; in_ready = 0; out_valid = 0;
    out_data = 8'h00;
    epa_has = 0; epa_tv = 0; epa_tl = 0; epa_td = 8'h00; epa_rr = 0;
    epb_has = 0; epb_tv = 0; epb_tl = 0; epb_td = 8'h00; epb_rr = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_in_xfer", {31'd0, epa_in_xfer}, 32'd0);
    check("rst_out_tvalid", {31'd0, epa_otv}, 32'd0);
    check("rst_out_tdata", {24'd0, epa_otd}, 32'd0);
    check("rst_in_valid", {31'd0, in_valid}, 32'd0);

    // 4-byte IN on endpoint A ending with tlast.
    ep = 4'd1; epa_has = 1; #1;
    check("a_has_data", {31'd0, has_data}, 32'd1);
    in_xfer = 1; tick();
    check("a_in_xfer", {31'd0, epa_in_xfer}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      epa_tv = 1; epa_td = 8'h10 + 8'(i); epa_tl = (i == 3); in_ready = 1; #1;
      check("a_data", {24'd0, in_data}, 32'h10 + i);
      check("a_valid", {31'd0, in_valid}, 32'd1);
      check("a_last", {31'd0, in_last}, (i == 3) ? 32'd1 : 32'd0);
      check("a_epb_tready", {31'd0, epb_tr}, 32'd0);
      tick();
    end
    epa_tv = 0; epa_tl = 0; in_xfer = 0; tick();
    check("a_in_xfer_done", {31'd0, epa_in_xfer}, 32'd0);

    // Endpoint B streams 20 bytes without tlast; cut at 8.
    ep = 4'd2; epb_has = 1; in_xfer = 1; tick();
    check("b_in_xfer", {31'd0, epb_in_xfer}, 32'd1);
    beats = 0;
    for (int i = 0; i < 20; i++) begin
      epb_tv = 1; epb_td = 8'(i); #1;
      check("b_valid", {31'd0, in_valid}, (i < 8) ? 32'd1 : 32'd0);
      if (i == 7) check("b_forced_last", {31'd0, in_last}, 32'd1);
      if (i >= 8) check("b_tready_blocked", {31'd0, epb_tr}, 32'd0);
      if (in_valid && in_ready) beats++;
      tick();
    end
    check("b_beats", beats, 32'd8);
    epb_tv = 0; in_xfer = 0; tick();

    // OUT on endpoint B: A1, A2, A3.
    epb_rr = 1; #1;
    check("b_ready_read", {31'd0, ready_read}, 32'd1);
    out_xfer = 1; tick();
    check("b_out_xfer", {31'd0, epb_out_xfer}, 32'd1);
    out_valid = 1; out_data = 8'hA1; tick();
    out_data = 8'hA2; tick();
    out_data = 8'hA3; tick();
    out_valid = 0; tick();
    check("b_no_early_last", {31'd0, epb_otl}, 32'd0);
    out_xfer = 0; tick();
    check("b_last_valid", {31'd0, epb_otv}, 32'd1);
    check("b_last_flag", {31'd0, epb_otl}, 32'd1);
    check("b_last_data", {24'd0, epb_otd}, 32'hA3);
    tick();
    check("b_after_last", {31'd0, epb_otv}, 32'd0);
    check("b_out_count", epb_q_data.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < epb_q_data.size()) begin
        check("b_out_data", {24'd0, epb_q_data[i]}, 32'hA1 + i);
        check("b_out_lastq", {31'd0, epb_q_last[i]}, (i == 2) ? 32'd1 : 32'd0);
      end
    end

    // Unmatched endpoint 5.
    ep = 4'd5; epa_rr = 1; #1;
    check("drop_has_data", {31'd0, has_data}, 32'd0);
    check("drop_ready_read", {31'd0, ready_read}, 32'd0);
    in_xfer = 1; epa_tv = 1; tick();
    check("drop_in_valid", {31'd0, in_valid}, 32'd0);
    check("drop_epa_tready", {31'd0, epa_tr}, 32'd0);
    check("drop_in_xfers", {30'd0, epa_in_xfer, epb_in_xfer}, 32'd0);
    in_xfer = 0; epa_tv = 0; tick();
    out_xfer = 1; tick();
    out_valid = 1; out_data = 8'h55; tick();
    out_data = 8'h66; tick();
    out_valid = 0; out_xfer = 0; tick(); tick();
    check("drop_out_xfers", {30'd0, epa_out_xfer, epb_out_xfer}, 32'd0);
    check("drop_no_beats", epa_beats + epb_q_data.size(), 32'd3);

    // IN and OUT together on EP 1: IN wins (also proves return to IDLE).
    ep = 4'd1; in_xfer = 1; out_xfer = 1; tick();
    check("prio_in", {31'd0, epa_in_xfer}, 32'd1);
    check("prio_no_out", {31'd0, epa_out_xfer}, 32'd0);
    in_xfer = 0; out_xfer = 0; tick();

    // Reset mid-OUT discards the held byte.
    out_xfer = 1; tick();
    out_valid = 1; out_data = 8'hB1; tick();
    out_data = 8'hB2; tick();
    out_valid = 0;
    check("rst_mid_pre", {31'd0, epa_otv}, 32'd1);
    rst = 1; tick();
    check("rst_mid_tvalid", {31'd0, epa_otv}, 32'd0);
    check("rst_mid_tlast", {31'd0, epa_otl}, 32'd0);
    check("rst_mid_tdata", {24'd0, epa_otd}, 32'd0);
    check("rst_mid_xfer", {31'd0, epa_out_xfer}, 32'd0);
    rst = 0; out_xfer = 0; tick(); tick();
    check("rst_mid_beats", epa_beats, 32'd1);
    check("rst_mid_lasts", epa_lasts, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
